// File: rtl/fft_stage_ctrl.sv
// Control for one radix-2 SDF FFT stage: fill/run/drain sequencing,
// butterfly phase select, twiddle index and one-cycle input delay.
module fft_stage_ctrl #(
  parameter int DELAY = 16,
  parameter int N     = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               valid_i,
  input  logic signed [16:0] data_in_r,
  input  logic signed [16:0] data_in_i,
  output logic               valid_o,
  output logic               bf_en,
  output logic [3:0]         tw_idx,
  output logic               sof_o,
  output logic               err_o,
  output logic signed [16:0] data_out_r,
  output logic signed [16:0] data_out_i
);

  localparam int SW = $clog2(N);
  localparam int B  = $clog2(DELAY);
  localparam int SH = 4 - B;   // step = 16/DELAY is a power of two

  typedef enum logic [1:0] {IDLE, FILL, RUN, DRAIN} state_t;

  state_t        state;
  logic [SW-1:0] s, j;
  logic [SW-1:0] s_nxt, j_nxt, s_mod;
  logic          acc_bf;
  logic [3:0]    acc_tw, drn_tw;

  assign s_nxt  = (s == SW'(N - 1)) ? '0 : s + 1'b1;
  assign s_mod  = s & SW'(DELAY - 1);
  assign acc_bf = s[B];
  assign acc_tw = acc_bf ? 4'd0 : 4'(s_mod << SH);
  assign j_nxt  = j + 1'b1;
  assign drn_tw = 4'(j_nxt << SH);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      s          <= '0;
      j          <= '0;
      valid_o    <= 1'b0;
      bf_en      <= 1'b0;
      tw_idx     <= '0;
      sof_o      <= 1'b0;
      err_o      <= 1'b0;
      data_out_r <= '0;
      data_out_i <= '0;
    end else begin
      // Default every output to the idle value; branches override.
      valid_o    <= 1'b0;
      bf_en      <= 1'b0;
      tw_idx     <= '0;
      sof_o      <= 1'b0;
      err_o      <= 1'b0;
      data_out_r <= '0;
      data_out_i <= '0;
      case (state)
        IDLE: begin
          if (valid_i) begin
            data_out_r <= data_in_r;
            data_out_i <= data_in_i;
            bf_en      <= acc_bf;
            tw_idx     <= acc_tw;
            s          <= s_nxt;
            state      <= (DELAY == 1) ? RUN : FILL;
          end
        end
        FILL: begin
          if (valid_i) begin
            data_out_r <= data_in_r;
            data_out_i <= data_in_i;
            bf_en      <= acc_bf;
            tw_idx     <= acc_tw;
            s          <= s_nxt;
            if (s == SW'(DELAY - 1)) state <= RUN;
          end else begin
            err_o <= 1'b1;
            s     <= '0;
            state <= IDLE;
          end
        end
        RUN: begin
          if (valid_i) begin
            data_out_r <= data_in_r;
            data_out_i <= data_in_i;
            bf_en      <= acc_bf;
            tw_idx     <= acc_tw;
            valid_o    <= 1'b1;
            sof_o      <= (s == SW'(DELAY));
            s          <= s_nxt;
          end else if (s == '0) begin
            // Frame ended cleanly: flush the feedback register, j = 0 first.
            valid_o <= 1'b1;
            j       <= '0;
            state   <= DRAIN;
          end else begin
            err_o <= 1'b1;
            s     <= '0;
            state <= IDLE;
          end
        end
        DRAIN: begin
          err_o <= valid_i;
          if (j == SW'(DELAY - 1)) begin
            j     <= '0;
            state <= IDLE;
          end else begin
            valid_o <= 1'b1;
            tw_idx  <= drn_tw;
            j       <= j_nxt;
          end
        end
        default: begin
          s     <= '0;
          j     <= '0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fft_stage_ctrl.sv
// Directed bench for fft_stage_ctrl with DELAY = 4, N = 32.
module tb_fft_stage_ctrl;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               valid_i;
  logic signed [16:0] data_in_r, data_in_i;
  logic               valid_o, bf_en, sof_o, err_o;
  logic [3:0]         tw_idx;
  logic signed [16:0] data_out_r, data_out_i;

  int checks = 0;
  int errors = 0;

  fft_stage_ctrl #(.DELAY(4), .N(32)) dut (
    .clk(clk), .rst_n(rst_n), .valid_i(valid_i),
    .data_in_r(data_in_r), .data_in_i(data_in_i),
    .valid_o(valid_o), .bf_en(bf_en), .tw_idx(tw_idx),
    .sof_o(sof_o), .err_o(err_o),
    .data_out_r(data_out_r), .data_out_i(data_out_i)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [16:0] obs, input logic [16:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input int s);
    valid_i   = v;
    data_in_r = 17'(s);
    data_in_i = 17'h10000 | 17'(s);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, ".valid"}, 17'(valid_o), 17'd0);
    chk({tag, ".bf"},    17'(bf_en),   17'd0);
    chk({tag, ".tw"},    17'(tw_idx),  17'd0);
    chk({tag, ".sof"},   17'(sof_o),   17'd0);
    chk({tag, ".err"},   17'(err_o),   17'd0);
    chk({tag, ".dr"},    data_out_r,   17'd0);
    chk({tag, ".di"},    data_out_i,   17'd0);
  endtask

  // One full frame data_in_r = s, then drain and return to idle.
  task automatic single_frame(input string tag);
    int vcnt;
    logic exp_bf;
    vcnt = 0;
    for (int s = 0; s < 32; s++) begin
      drive(1'b1, s);
      tick();
      exp_bf = ((s / 4) % 2) == 1;
      if (valid_o) vcnt++;
      chk({tag, ".dr"},    data_out_r, 17'(s));
      chk({tag, ".di"},    data_out_i, 17'h10000 | 17'(s));
      chk({tag, ".bf"},    17'(bf_en), 17'(exp_bf));
      chk({tag, ".tw"},    17'(tw_idx), exp_bf ? 17'd0 : 17'((s % 4) * 4));
      chk({tag, ".valid"}, 17'(valid_o), 17'(s >= 4));
      chk({tag, ".sof"},   17'(sof_o), 17'(s == 4));
      chk({tag, ".err"},   17'(err_o), 17'd0);
    end
    for (int jj = 0; jj < 4; jj++) begin
      drive(1'b0, 0);
      tick();
      if (valid_o) vcnt++;
      chk({tag, ".drn_valid"}, 17'(valid_o), 17'd1);
      chk({tag, ".drn_dr"},    data_out_r, 17'd0);
      chk({tag, ".drn_bf"},    17'(bf_en), 17'd0);
      chk({tag, ".drn_tw"},    17'(tw_idx), 17'(jj * 4));
      chk({tag, ".drn_sof"},   17'(sof_o), 17'd0);
    end
    tick();
    chk_zero({tag, ".idle"});
    chk({tag, ".vcnt"}, 17'(vcnt), 17'd32);
  endtask

  initial begin
    int vcnt, sofs, first_v, last_v, first_sof, last_sof;

    // Reset with busy-looking inputs: everything must be zero.
    rst_n = 1'b0;
    drive(1'b1, 7);
    tick();
    tick();
    chk_zero("reset");

    rst_n = 1'b1;
    drive(1'b0, 0);
    tick();
    chk_zero("post_reset_idle");

    single_frame("frame1");

    // Two back-to-back frames: 64 contiguous valid cycles, sof 32 apart.
    vcnt = 0; sofs = 0; first_v = -1; last_v = -1; first_sof = -1; last_sof = -1;
    for (int i = 0; i < 69; i++) begin
      drive(i < 64, i % 32);
      tick();
      if (valid_o) begin
        vcnt++;
        if (first_v < 0) first_v = i;
        last_v = i;
      end
      if (sof_o) begin
        sofs++;
        if (first_sof < 0) first_sof = i;
        last_sof = i;
      end
    end
    chk("b2b.vcnt",       17'(vcnt), 17'd64);
    chk("b2b.contiguous", 17'(last_v - first_v + 1), 17'd64);
    chk("b2b.sofs",       17'(sofs), 17'd2);
    chk("b2b.sof_gap",    17'(last_sof - first_sof), 17'd32);
    chk("b2b.first_sof",  17'(first_sof), 17'd4);
    chk_zero("b2b.idle");

    // Mid-frame drop after s = 10.
    for (int s = 0; s <= 10; s++) begin
      drive(1'b1, s);
      tick();
    end
    chk("drop.pre_valid", 17'(valid_o), 17'd1);
    drive(1'b0, 0);
    tick();
    chk("drop.err",   17'(err_o), 17'd1);
    chk("drop.valid", 17'(valid_o), 17'd0);
    chk("drop.dr",    data_out_r, 17'd0);
    chk("drop.bf",    17'(bf_en), 17'd0);
    tick();
    chk_zero("drop.idle");

    // valid_i pulsed during drain (edge producing j = 2).
    vcnt = 0;
    for (int s = 0; s < 32; s++) begin
      drive(1'b1, s);
      tick();
      if (valid_o) vcnt++;
    end
    drive(1'b0, 0);
    tick(); if (valid_o) vcnt++;
    tick(); if (valid_o) vcnt++;
    drive(1'b1, 99);
    tick(); if (valid_o) vcnt++;
    chk("drnerr.err",   17'(err_o), 17'd1);
    chk("drnerr.tw",    17'(tw_idx), 17'd8);
    chk("drnerr.dr",    data_out_r, 17'd0);
    drive(1'b0, 0);
    tick(); if (valid_o) vcnt++;
    chk("drnerr.err_clr", 17'(err_o), 17'd0);
    chk("drnerr.tw3",     17'(tw_idx), 17'd12);
    chk("drnerr.valid3",  17'(valid_o), 17'd1);
    tick(); if (valid_o) vcnt++;
    chk_zero("drnerr.idle");
    chk("drnerr.vcnt", 17'(vcnt), 17'd32);

    // Reset for two edges mid-RUN at s = 20, then a clean frame.
    for (int s = 0; s <= 20; s++) begin
      drive(1'b1, s);
      tick();
    end
    chk("rstrun.pre_valid", 17'(valid_o), 17'd1);
    rst_n = 1'b0;
    tick();
    chk_zero("rstrun.r1");
    tick();
    chk_zero("rstrun.r2");
    rst_n = 1'b1;
    single_frame("frame_after_rst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
